// File: rtl/moore_step_sequencer.sv
// moore_step_sequencer
// Moore step sequencer: walks a WIDTH-bit step value through 0..LIMIT,
// up or down, holding each value for DWELL clocks while running.
// The output code is binary or Gray. Free-running mode wraps around at the
// ends of the range. One-shot mode parks at the terminal value in DONE.
// Every output is decoded from registered state only.

module moore_step_sequencer #(
    parameter int WIDTH    = 2,
    parameter int LIMIT    = 3,
    parameter int DWELL    = 1,
    parameter int ENCODING = 0,
    parameter int ONE_SHOT = 0
) (
    input  logic             inputClk,
    input  logic             inputReset,
    input  logic             inputI,
    input  logic             inputS,
    output logic [WIDTH-1:0] outputB,
    output logic             outputRunning,
    output logic             outputWrap,
    output logic             outputDone
);

    localparam int DW = $clog2(DWELL + 1);

    localparam logic [WIDTH-1:0] STEP_LIMIT = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] STEP_ZERO  = '0;
    localparam logic [WIDTH-1:0] STEP_ONE   = WIDTH'(1);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [DW-1:0]    DWELL_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_step;
    logic [DW-1:0]    r_dwell;
    logic             r_wrap;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_step_nxt;
    logic [DW-1:0]    w_dwell_nxt;
    logic             w_wrap_nxt;

    logic             w_at_end;
    logic [WIDTH-1:0] w_step_adv;

    // Advance target for the current direction, plus a flag for the wrap boundary
    always_comb begin
        w_at_end   = 1'b0;
        w_step_adv = r_step;
        if (inputS) begin
            w_at_end   = (r_step == STEP_ZERO);
            w_step_adv = w_at_end ? STEP_LIMIT : (r_step - STEP_ONE);
        end else begin
            w_at_end   = (r_step == STEP_LIMIT);
            w_step_adv = w_at_end ? STEP_ZERO : (r_step + STEP_ONE);
        end
    end

    // Next-state logic for the fsm, step, dwell counter and wrap flag
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_dwell_nxt = r_dwell;
        w_wrap_nxt  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (inputI) begin
                    w_state_nxt = ST_RUN;
                    w_dwell_nxt = '0;
                end
            end

            ST_RUN: begin
                if (!inputI) begin
                    // Pause: step is kept so a later run resumes where it left off
                    w_state_nxt = ST_IDLE;
                    w_dwell_nxt = '0;
                end else if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (w_at_end && (ONE_SHOT != 0)) begin
                        // Terminal value reached: hold it and do not flag a wrap
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_step_nxt = w_step_adv;
                        w_wrap_nxt = w_at_end;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DWELL_ONE;
                end
            end

            ST_DONE: begin
                if (!inputI) begin
                    w_state_nxt = ST_IDLE;
                    w_step_nxt  = '0;
                    w_dwell_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_dwell_nxt = '0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge inputClk or posedge inputReset) begin
        if (inputReset) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_dwell <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_dwell <= w_dwell_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Output decode from registered state only
    always_comb begin
        if (ENCODING != 0) begin
            outputB = r_step ^ (r_step >> 1);
        end else begin
            outputB = r_step;
        end
        outputRunning = (r_state == ST_RUN);
        outputDone    = (r_state == ST_DONE);
        outputWrap    = r_wrap;
    end

endmodule

// File: tb/tb_moore_step_sequencer.sv
// Scoreboard bench for moore_step_sequencer. Three instances share stimulus:
// A: WIDTH=3 LIMIT=5 DWELL=3 Gray, free-run
// B: WIDTH=2 LIMIT=3 DWELL=1 binary, one-shot
// C: WIDTH=2 LIMIT=3 DWELL=1 binary, free-run
// The stimulus process queues the expected outputs for each edge.
// A monitor process checks those expectations after each edge.

module tb_moore_step_sequencer;

    typedef struct {
        int mode;   // 0 idle, 1 running, 2 done
        int step;
        int held;   // cycles the current value has been held while running
        bit wrap;
    } model_t;

    typedef struct packed {
        logic [2:0] b;
        logic       run;
        logic       wrap;
        logic       done;
    } obs_t;

    logic clk, rst, in_i, in_s;
    logic [2:0] bA;
    logic [1:0] bB, bC;
    logic runA, wrapA, doneA, runB, wrapB, doneB, runC, wrapC, doneC;

    int n_cmp = 0;
    int n_bad = 0;

    obs_t qa[$];
    obs_t qb[$];
    obs_t qc[$];
    model_t ma, mb, mc;

    moore_step_sequencer #(.WIDTH(3), .LIMIT(5), .DWELL(3), .ENCODING(1), .ONE_SHOT(0)) u_a (
        .inputClk(clk), .inputReset(rst), .inputI(in_i), .inputS(in_s),
        .outputB(bA), .outputRunning(runA), .outputWrap(wrapA), .outputDone(doneA));

    moore_step_sequencer #(.WIDTH(2), .LIMIT(3), .DWELL(1), .ENCODING(0), .ONE_SHOT(1)) u_b (
        .inputClk(clk), .inputReset(rst), .inputI(in_i), .inputS(in_s),
        .outputB(bB), .outputRunning(runB), .outputWrap(wrapB), .outputDone(doneB));

    moore_step_sequencer #(.WIDTH(2), .LIMIT(3), .DWELL(1), .ENCODING(0), .ONE_SHOT(0)) u_c (
        .inputClk(clk), .inputReset(rst), .inputI(in_i), .inputS(in_s),
        .outputB(bC), .outputRunning(runC), .outputWrap(wrapC), .outputDone(doneC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour for one clock edge, in terms of the range 0..lim
    function automatic model_t ref_edge(model_t m, bit i, bit s, int lim, int dw, bit os);
        model_t n;
        bit     crosses;
        n = m;
        n.wrap = 1'b0;
        crosses = s ? (m.step == 0) : (m.step == lim);
        if (m.mode == 1) begin
            if (!i) begin
                n.mode = 0;
                n.held = 0;
            end else if (m.held + 1 < dw) begin
                n.held = m.held + 1;
            end else begin
                n.held = 0;
                if (crosses && os) begin
                    n.mode = 2;
                end else begin
                    n.step = s ? (m.step + lim) % (lim + 1) : (m.step + 1) % (lim + 1);
                    n.wrap = crosses;
                end
            end
        end else if (m.mode == 2) begin
            if (!i) begin
                n.mode = 0;
                n.step = 0;
            end
        end else begin
            if (i) begin
                n.mode = 1;
                n.held = 0;
            end
        end
        return n;
    endfunction

    function automatic obs_t expect_of(model_t m, bit gray);
        obs_t o;
        int   code;
        code = gray ? (m.step ^ (m.step >> 1)) : m.step;
        o.b    = 3'(code);
        o.run  = (m.mode == 1);
        o.wrap = m.wrap;
        o.done = (m.mode == 2);
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got b=%0d run=%0b wrap=%0b done=%0b, expected b=%0d run=%0b wrap=%0b done=%0b",
                     name, $time, act.b, act.run, act.wrap, act.done,
                     exp.b, exp.run, exp.wrap, exp.done);
        end
    endtask

    function automatic obs_t act_a();
        obs_t o;
        o.b = bA; o.run = runA; o.wrap = wrapA; o.done = doneA;
        return o;
    endfunction

    function automatic obs_t act_b();
        obs_t o;
        o.b = {1'b0, bB}; o.run = runB; o.wrap = wrapB; o.done = doneB;
        return o;
    endfunction

    function automatic obs_t act_c();
        obs_t o;
        o.b = {1'b0, bC}; o.run = runC; o.wrap = wrapC; o.done = doneC;
        return o;
    endfunction

    // Drives one cycle of stimulus between edges and queues what the next edge must produce
    task automatic apply(input bit i, input bit s, input bit r);
        obs_t zero;
        zero = '0;
        @(negedge clk);
        in_i = i;
        in_s = s;
        rst  = r;
        if (r) begin
            ma = '{default: 0};
            mb = '{default: 0};
            mc = '{default: 0};
            #1;
            check("A_async_reset", act_a(), zero);
            check("B_async_reset", act_b(), zero);
            check("C_async_reset", act_c(), zero);
        end else begin
            ma = ref_edge(ma, i, s, 5, 3, 1'b0);
            mb = ref_edge(mb, i, s, 3, 1, 1'b1);
            mc = ref_edge(mc, i, s, 3, 1, 1'b0);
        end
        qa.push_back(expect_of(ma, 1'b1));
        qb.push_back(expect_of(mb, 1'b0));
        qc.push_back(expect_of(mc, 1'b0));
    endtask

    // Monitor: after every active edge compare each instance against its queued expectation
    always begin
        @(posedge clk);
        #1;
        if (qa.size() > 0) check("A_step", act_a(), qa.pop_front());
        if (qb.size() > 0) check("B_step", act_b(), qb.pop_front());
        if (qc.size() > 0) check("C_step", act_c(), qc.pop_front());
    end

    initial begin
        obs_t zero;
        obs_t left;
        bit   ri, rs;
        zero = '0;
        rst  = 1'b1;
        in_i = 1'b0;
        in_s = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};
        mc = '{default: 0};
        #2;
        check("A_reset", act_a(), zero);
        check("B_reset", act_b(), zero);
        check("C_reset", act_c(), zero);

        // Up run: free-run wraps, one-shot parks in DONE at 3
        for (int k = 0; k < 16; k++) apply(1'b1, 1'b0, 1'b0);
        // Pause and resume
        for (int k = 0; k < 2; k++) apply(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) apply(1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0);
        // Down run with wrap at zero
        for (int k = 0; k < 14; k++) apply(1'b1, 1'b1, 1'b0);
        // Direction flipping every cycle, including in the middle of a dwell
        for (int k = 0; k < 10; k++) apply(1'b1, k[0], 1'b0);
        // Reset between edges during a run, then restart from zero
        apply(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) apply(1'b1, 1'b0, 1'b0);

        // Random run: run request mostly high, direction changes occasionally
        rs = 1'b0;
        for (int k = 0; k < 400; k++) begin
            ri = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 10) rs = ~rs;
            apply(ri, rs, ($urandom_range(0, 99) < 2));
        end
        apply(1'b0, 1'b0, 1'b0);

        // Let the monitor drain; every queued expectation must be consumed
        @(negedge clk);
        @(negedge clk);
        left = '0;
        left.b = 3'(qa.size() + qb.size() + qc.size());
        check("queues_drained", left, zero);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
